// File: rtl/trap_entry_ctrl_pkg.sv
// trap_entry_ctrl_pkg: shared trap-entry state encoding and RISC-V cause codes.
package trap_entry_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam int CAUSE_INSTR_PAGE_FAULT   = 12;
    localparam int CAUSE_INSTR_ACCESS_FAULT = 1;
    localparam int CAUSE_ILLEGAL_INSTR      = 2;

endpackage

// File: rtl/trap_entry_ctrl_prio.sv
// trap_cause_prio: priority-encodes the delayed instruction fault flags into a cause code.
module trap_cause_prio
    import trap_entry_ctrl_pkg::*;
#(
    parameter int CAUSEW = 5
) (
    input  logic              page_fault,
    input  logic              access_fault,
    input  logic              hptw_fault,
    input  logic              illegal,
    output logic [CAUSEW-1:0] cause,
    output logic              valid
);

    assign valid = page_fault | access_fault | hptw_fault | illegal;

    always_comb begin
        cause = '0;
        cause = page_fault                  ? CAUSEW'(CAUSE_INSTR_PAGE_FAULT)   :
                (access_fault | hptw_fault) ? CAUSEW'(CAUSE_INSTR_ACCESS_FAULT) :
                illegal                     ? CAUSEW'(CAUSE_ILLEGAL_INSTR)      : '0;
    end

endmodule

// File: rtl/trap_entry_ctrl.sv
// trap_entry_ctrl: stalls on a delayed M-stage instruction fault until the LSU drains,
// then commits the trap with a full flush and redirects fetch to the trap vector.
module trap_entry_ctrl
    import trap_entry_ctrl_pkg::*;
#(
    parameter int CAUSEW = 5,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InstrValidM,
    input  logic              InstrPageFaultM,
    input  logic              InstrAccessFaultM,
    input  logic              HPTWInstrAccessFaultM,
    input  logic              IllegalIEUFPUInstrM,
    input  logic              LSUBusyM,
    output logic              StallTrap,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic              TrapM,
    output logic [CAUSEW-1:0] CauseM,
    output logic              PCRedirectF,
    output logic [CNTW-1:0]   TrapCount
);

    state_t            state, next;
    logic [CAUSEW-1:0] cause_reg, prio_cause;
    logic              prio_valid, fault;

    trap_cause_prio #(.CAUSEW(CAUSEW)) u_prio (
        .page_fault   (InstrPageFaultM),
        .access_fault (InstrAccessFaultM),
        .hptw_fault   (HPTWInstrAccessFaultM),
        .illegal      (IllegalIEUFPUInstrM),
        .cause        (prio_cause),
        .valid        (prio_valid)
    );

    assign fault = InstrValidM & prio_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cause_reg <= '0;
            TrapCount <= '0;
        end else begin
            state <= next;
            if (state == IDLE && fault)
                cause_reg <= prio_cause;
            if (state == COMMIT && !(&TrapCount))
                TrapCount <= TrapCount + CNTW'(1);
        end
    end

    // Faults are only sampled in IDLE; later states see a pipeline that is already being flushed.
    always_comb begin
        next        = state;
        StallTrap   = 1'b0;
        TrapM       = 1'b0;
        CauseM      = '0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;
        PCRedirectF = 1'b0;
        unique case (state)
            IDLE: begin
                StallTrap = fault;
                if (fault)
                    next = LSUBusyM ? DRAIN : COMMIT;
            end
            DRAIN: begin
                StallTrap = 1'b1;
                if (!LSUBusyM)
                    next = COMMIT;
            end
            COMMIT: begin
                TrapM  = 1'b1;
                CauseM = cause_reg;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushM = 1'b1;
                FlushW = 1'b1;
                next   = REDIRECT;
            end
            REDIRECT: begin
                PCRedirectF = 1'b1;
                FlushD      = 1'b1;
                FlushE      = 1'b1;
                next        = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: doc/trap_entry_ctrl.md
# trap_entry_ctrl

Sequences trap entry for instruction-side faults after they reach the Memory stage through the privileged fault pipeline. Detects a delayed fault on a valid M-stage instruction, prioritizes it into a RISC-V cause code, and stalls the pipeline until outstanding LSU activity drains. It then pulses the trap commit with a full flush and issues a one-cycle PC redirect. Sits in the privileged unit between the fault pipeline registers and the CSR/trap-vector logic; it also drives the stall and flush controls those registers consume.

## Interface
- CAUSEW, 5: width of the cause code output.
- CNTW, 16: width of the saturating trap counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- InstrValidM  in  1  M stage holds a real instruction.
- InstrPageFaultM, InstrAccessFaultM, HPTWInstrAccessFaultM, IllegalIEUFPUInstrM  in  1 each  delayed fault flags.
- LSUBusyM  in  1  LSU has an outstanding bus or page-table-walk transaction.
- StallTrap  out  1  ORed into StallF/D/E/M by the hazard unit.
- FlushD, FlushE, FlushM, FlushW  out  1 each  trap flush requests.
- TrapM  out  1  single-cycle trap commit to the CSR unit.
- CauseM  out  CAUSEW  cause code, valid while TrapM is high.
- PCRedirectF  out  1  selects the trap vector as the next fetch PC.
- TrapCount  out  CNTW  number of committed traps.

## Operation
- FaultM = InstrValidM & (InstrPageFaultM | InstrAccessFaultM | HPTWInstrAccessFaultM | IllegalIEUFPUInstrM).
- Cause priority, highest first:
  - InstrPageFaultM → 12.
  - InstrAccessFaultM or HPTWInstrAccessFaultM → 1.
  - IllegalIEUFPUInstrM → 2.
  - Cause values are zero-extended to CAUSEW.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - If FaultM is high, capture the prioritized cause into CauseReg.
  - Next state is DRAIN if LSUBusyM is high, otherwise COMMIT.
  - StallTrap is asserted combinationally in the same cycle FaultM is detected.
- DRAIN:
  - StallTrap = 1.
  - Leave for COMMIT in the first cycle LSUBusyM is low.
  - The wait has no bound.
  - Fault inputs are ignored; CauseReg is held.
- COMMIT:
  - TrapM = 1 and CauseM = CauseReg.
  - FlushD, FlushE, FlushM and FlushW are all 1; StallTrap = 0.
  - TrapCount increments, saturating at all ones.
  - Always moves to REDIRECT.
- REDIRECT:
  - PCRedirectF = 1; FlushD = 1 and FlushE = 1 to kill wrong-path fetch.
  - Fault inputs are ignored.
  - Always moves to IDLE.
- CauseM is driven to 0 whenever TrapM is low.

## Timing
- Reset: state = IDLE, CauseReg = 0, TrapCount = 0. Every output is 0 while reset is asserted, except StallTrap, which is combinational.
- Fault detected in cycle N with LSU idle:
  - TrapM and the full flush occur in N+1.
  - PCRedirectF occurs in N+2.
  - IDLE again in N+3.
- With LSU busy: TrapM occurs one cycle after the first LSUBusyM-low cycle in DRAIN.
- Back-to-back faults: a fault present in the cycle after REDIRECT is treated as new, because the pipeline was flushed. No fault is accepted in COMMIT or REDIRECT.
- Simultaneous fault flags resolve by priority only; one trap is issued.
- Reset asserted mid-sequence: immediate return to IDLE with outputs cleared; no partial TrapM pulse.

## Structure
- Shared privileged package holds:
  - the state enum (2 bits);
  - cause constants CAUSE_INSTR_PAGE_FAULT = 12, CAUSE_INSTR_ACCESS_FAULT = 1, CAUSE_ILLEGAL_INSTR = 2.
- One natural sub-module, trap_cause_prio: a combinational priority encoder from the four flags to a cause code plus a valid bit.
- The counter and FSM live in the top module.

## Test plan
- LSU idle, InstrPageFaultM = 1 and InstrValidM = 1 in cycle 5:
  - StallTrap = 1 in cycle 5;
  - TrapM = 1, CauseM = 12 and all flushes = 1 in cycle 6;
  - PCRedirectF = 1 in cycle 7;
  - TrapCount = 1.
- InstrAccessFaultM and IllegalIEUFPUInstrM together, LSUBusyM high for 4 cycles:
  - StallTrap is held for 5 cycles;
  - then a single TrapM with CauseM = 1.
- HPTWInstrAccessFaultM only → CauseM = 1; IllegalIEUFPUInstrM only → CauseM = 2.
- Fault flag asserted with InstrValidM = 0 → no stall and no TrapM.
- Reset asserted while in DRAIN → all outputs 0 next cycle, TrapCount = 0; a later fault sequences normally.
- With CNTW = 2, five consecutive traps → TrapCount saturates at 3.
